poly_canon_reduce: RTL

// Back end of the squaring datapath. Takes a redundant polynomial (I_WORD coefs of

---
 rtl/poly_canon_reduce.sv | 134 +++++++++++++
 1 files changed

// File: rtl/poly_canon_reduce.sv
`timescale 1ns/1ps
// Turns a redundant polynomial into the canonical integer in [0, MODULUS) by a carry pass, then repeated MODULUS subtraction.
// Latency: o_val rises (k+2)*W+1 cycles after accept for k<MAX_SUB subtractions, or (MAX_SUB+1)*W+1 cycles when o_err is set.
// Single transaction in flight: o_rdy is high only in IDLE, and i_val is ignored while busy (nothing is queued).
module poly_canon_reduce #(
  parameter int WORD_BITS = 32,
  parameter int NUM_WORDS = 32,
  parameter int REDUN_WORD_BITS = 1,
  parameter int I_WORD = NUM_WORDS + 1,
  parameter int COEF_BITS = WORD_BITS + REDUN_WORD_BITS,
  parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = {NUM_WORDS{32'hDEAD_BEEF}},
  parameter int MAX_SUB = 15,
  localparam int CNT_BITS = $clog2(MAX_SUB + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_val,
  input  logic [I_WORD-1:0][COEF_BITS-1:0]     i_dat,
  output logic                                 o_rdy,
  output logic                                 o_val,
  output logic [WORD_BITS*NUM_WORDS-1:0]       o_dat,
  output logic [CNT_BITS-1:0]                  o_sub_count,
  output logic                                 o_err
);

  localparam int W  = I_WORD + 1;
  localparam int KW = $clog2(W);
  localparam int CB = REDUN_WORD_BITS + 1;
  localparam logic [W*WORD_BITS-1:0] MOD_PAD = (W*WORD_BITS)'(MODULUS);

  typedef enum logic [1:0] {IDLE, CARRY, SUB, DONE} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [COEF_BITS-1:0] coef_q [W];
  logic [WORD_BITS-1:0] acc_q  [W];
  logic [WORD_BITS-1:0] shd_q  [W];
  logic [CB-1:0]        c_q;
  logic                 b_q;

  logic                 last, cnt_max, cnt_next_max, borrow_d, commit, accept;
  logic [COEF_BITS:0]   csum;
  logic [WORD_BITS:0]   diff;
  logic [WORD_BITS-1:0] mod_word;

  assign o_rdy = (state_q == IDLE);

  always_comb begin
    last         = (k_q == KW'(W - 1));
    cnt_max      = (o_sub_count == CNT_BITS'(MAX_SUB));
    cnt_next_max = ((o_sub_count + CNT_BITS'(1)) == CNT_BITS'(MAX_SUB));
    mod_word     = MOD_PAD[k_q*WORD_BITS +: WORD_BITS];
    csum         = {1'b0, coef_q[k_q]} + (COEF_BITS+1)'(c_q);
    diff         = {1'b0, acc_q[k_q]} - {1'b0, mod_word} - (WORD_BITS+1)'(b_q);
    borrow_d     = diff[WORD_BITS];
    accept       = (state_q == IDLE) && i_val;
    commit       = (state_q == SUB) && last && !borrow_d;
    state_d      = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = CARRY;
      CARRY: if (last) state_d = cnt_max ? DONE : SUB;
      // A borrow out of the top word means acc < MODULUS: the pass is discarded.
      SUB: begin
        if (last) begin
          if (borrow_d || cnt_next_max) state_d = DONE;
          else                          state_d = SUB;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < W; i++) begin
        coef_q[i] <= '0;
        acc_q[i]  <= '0;
        shd_q[i]  <= '0;
      end
      k_q         <= '0;
      c_q         <= '0;
      b_q         <= 1'b0;
      o_val       <= 1'b0;
      o_dat       <= '0;
      o_sub_count <= '0;
      o_err       <= 1'b0;
    end else begin
      o_val <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < I_WORD; i++) coef_q[i] <= i_dat[i];
            coef_q[W-1] <= '0;
            k_q         <= '0;
            c_q         <= '0;
            b_q         <= 1'b0;
            o_sub_count <= '0;
            o_err       <= 1'b0;
          end
        end
        CARRY: begin
          acc_q[k_q] <= csum[WORD_BITS-1:0];
          c_q        <= csum[WORD_BITS +: CB];
          k_q        <= last ? '0 : k_q + KW'(1);
          if (last && cnt_max) o_err <= 1'b1;
        end
        SUB: begin
          shd_q[k_q] <= diff[WORD_BITS-1:0];
          b_q        <= last ? 1'b0 : borrow_d;
          k_q        <= last ? '0 : k_q + KW'(1);
          // The top difference word is still in flight, so it bypasses the shadow.
          if (commit) begin
            for (int i = 0; i < W - 1; i++) acc_q[i] <= shd_q[i];
            acc_q[W-1]  <= diff[WORD_BITS-1:0];
            o_sub_count <= o_sub_count + CNT_BITS'(1);
            if (cnt_next_max) o_err <= 1'b1;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_WORDS; i++) o_dat[i*WORD_BITS +: WORD_BITS] <= acc_q[i];
          o_val <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
